// File: rtl/calc_queue.sv
// Circular operand queue for the calculator ALU: executes one queue command per
// cycle, presents the two oldest entries as operands, and locks up on misuse.
module calc_queue #(
  parameter int          DEPTH          = 16,
  parameter logic [1:0]  Q_PUSH         = 2'b00,
  parameter logic [1:0]  Q_SLEEP        = 2'b01,
  parameter logic [1:0]  Q_POP          = 2'b11,
  parameter logic [1:0]  Q_GET_AND_PUSH = 2'b10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  input  logic [1:0]                 queue_op,
  input  logic [7:0]                 result,
  output logic [15:0]                operands,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       has_q_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, ERROR} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic            err_q;

  logic            wr_en;
  logic [1:0]      pop_n;
  logic            q_err;
  logic [PW-1:0]   head_nxt;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign has_q_err = err_q;

  // Command decode; in ERROR nothing is accepted so all strobes stay low.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    wr_en = 1'b0;
    pop_n = 2'd0;
    q_err = 1'b0;
    if (state_q == RUN && op_valid) begin
      case (queue_op)
        Q_PUSH: begin
          if (!full) wr_en = 1'b1;
          else       q_err = 1'b1;
        end
        Q_POP: begin
          if (!empty) pop_n = 2'd1;
          else        q_err = 1'b1;
        end
        Q_GET_AND_PUSH: begin
          if (count_q >= CW'(2)) begin
            pop_n = 2'd2;
            wr_en = 1'b1;
          end else begin
            q_err = 1'b1;
          end
        end
        default: ;  // Q_SLEEP
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (q_err) begin
      state_q <= ERROR;
      err_q   <= 1'b1;
    end else begin
      head_q  <= head_q + PW'(pop_n);
      tail_q  <= tail_q + PW'(wr_en);
      count_q <= count_q + CW'(wr_en) - CW'(pop_n);
    end
  end

  // NOTE: the buffer is deliberately left out of reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[tail_q] <= result;
  end

  assign head_nxt = head_q + PW'(1);
  assign operands = {(count_q >= CW'(2)) ? mem_q[head_nxt] : 8'h00,
                     (count_q >= CW'(1)) ? mem_q[head_q]   : 8'h00};

endmodule
